pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the pipelined CPU, replacing hand-instantiated per-field flop banks between IF/ID, ID/EX, EX/MEM and MEM/WB. It captures a data payload and a control bundle, carries a valid bit, and supports hazard-unit stall (hold) and flush (bubble insertion). Optional performance counters track stall cycles, squashed instructions and the longest stall run.

## Interface

Parameters:
- DATA_W, 64: payload width (operands, PC, immediates, register numbers concatenated by the instantiating stage)
- CTRL_W, 16: control-bundle width (RegWrite, MemWrite, branch, ALUop, etc.); all-zero encodes a no-op
- CNT_W, 16: performance counter width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream stage holds a real instruction
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bundle
- stall  in  1  hold current contents this cycle
- flush  in  1  discard incoming instruction, load a bubble
- perf_clr  in  1  synchronous clear of all performance counters
- out_valid  out  1  registered valid
- out_data  out  DATA_W  registered payload
- out_ctrl  out  CTRL_W  registered control; guaranteed zero whenever out_valid=0
- stall_cnt  out  CNT_W  cycles spent stalled
- squash_cnt  out  CNT_W  valid instructions discarded by flush
- max_stall_run  out  CNT_W  longest run of consecutive stall cycles

## Operation

- Register update, evaluated at each rising clk edge in this priority order:
  - reset: out_valid=0, out_data=0, out_ctrl=0, all counters and the internal run counter = 0.
  - flush (regardless of stall): out_valid<=0, out_ctrl<=0, out_data held.
  - stall: out_valid, out_data, out_ctrl held.
  - otherwise: out_valid<=in_valid; out_data<=in_data; out_ctrl<=in_valid ? in_ctrl : 0.
- Invariant: out_valid=0 implies out_ctrl=0, so downstream never acts on a bubble's control bits.
- Run-length state (two states):
  - RUN: entered on reset or on any cycle that does not stall; internal run counter cur_run=0.
  - STALLED: an effective stall (stall=1, flush=0) increments cur_run (saturating); remains STALLED while effective stalls continue.
  - Leaving STALLED (non-stall or flush): max_stall_run<=max(max_stall_run, cur_run); cur_run<=0.
- Counters (all saturate at 2^CNT_W-1, never wrap):
  - stall_cnt +1 on each effective stall cycle.
  - squash_cnt +1 when flush=1 and in_valid=1.
- perf_clr: clears stall_cnt, squash_cnt, max_stall_run and cur_run; reset has priority; perf_clr has priority over same-cycle increments. Pipeline registers are not affected.

## Timing

- Latency 1 cycle: inputs sampled on edge N appear on outputs after edge N.
- All outputs registered; no combinational input-to-output path.
- stall, flush and in_* are sampled only at the edge; setup relative to clk only.
- Simultaneous stall and flush: flush wins; the cycle counts as a squash (if in_valid=1), not a stall, and ends any stall run.
- Reset mid-stall: all state cleared on that edge; the in-progress run is not folded into max_stall_run.
- Stall while out_valid=0 still counts as a stall cycle (the hazard unit owns the policy).
- max_stall_run updates one edge after the run ends, not live.

## Configuration

- PIPE_STAGE_PERF_EN defined: counters, run-length state and perf_clr logic are synthesised as described.
- Not defined: no counter flops are built; stall_cnt, squash_cnt and max_stall_run are tied to 0; perf_clr is ignored. Pipeline register behaviour is identical.

## Test plan

- Reset then pass-through: DATA_W=64, in_valid=1, in_data=0xDEAD_BEEF_0000_0001, in_ctrl=0x00A5 -> after 1 edge out_valid=1 with those values; all outputs 0 during reset.
- Stall hold: load 0x11, then stall=1 for 3 cycles with in_data=0x22 -> out_data stays 0x11 for 3 cycles; stall_cnt=3; after stall drops, max_stall_run=3 one edge later and out_data=0x22.
- Flush priority: stall=1, flush=1, in_valid=1, in_ctrl=0xFFFF -> out_valid=0, out_ctrl=0, out_data unchanged; squash_cnt=1, stall_cnt unchanged.
- Bubble control gating: in_valid=0, in_ctrl=0x00FF -> out_valid=0, out_ctrl=0.
- Saturation and clear: CNT_W=4, stall=1 for 20 cycles -> stall_cnt=15 and held; perf_clr=1 -> all counters 0 next edge while out_data is unchanged.
- Macro off: same stall sequence with PIPE_STAGE_PERF_EN undefined -> counters read 0; data path identical to macro-on run.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with stall/flush and optional perf counters
// Optional counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  input  logic              perf_clr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  squash_cnt,
  output logic [CNT_W-1:0]  max_stall_run
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Flush outranks stall; control is zeroed whenever valid is cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (!stall) begin
      valid_q <= in_valid;
      data_q  <= in_data;
      ctrl_q  <= in_valid ? in_ctrl : '0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ctrl  = ctrl_q;

`ifdef PIPE_STAGE_PERF_EN
  typedef enum logic {RUN, STALLED} run_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  run_state_e       state_q, state_d;
  logic [CNT_W-1:0] cur_run_q, cur_run_d;
  logic [CNT_W-1:0] max_run_q, max_run_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
  logic             eff_stall;

  assign eff_stall = stall && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      cur_run_q    <= '0;
      max_run_q    <= '0;
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_run_q    <= cur_run_d;
      max_run_q    <= max_run_d;
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  always_comb begin
    state_d      = eff_stall ? STALLED : RUN;
    cur_run_d    = '0;
    max_run_d    = max_run_q;
    stall_cnt_d  = stall_cnt_q;
    squash_cnt_d = squash_cnt_q;

    if (eff_stall) begin
      cur_run_d = (cur_run_q == CNT_MAX) ? cur_run_q : cur_run_q + 1'b1;
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
    end else if (state_q == STALLED && cur_run_q > max_run_q) begin
      // Run just ended: fold its length into the high-water mark.
      max_run_d = cur_run_q;
    end

    if (flush && in_valid && squash_cnt_q != CNT_MAX) squash_cnt_d = squash_cnt_q + 1'b1;

    if (perf_clr) begin
      cur_run_d    = '0;
      max_run_d    = '0;
      stall_cnt_d  = '0;
      squash_cnt_d = '0;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign squash_cnt    = squash_cnt_q;
  assign max_stall_run = max_run_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;

  assign stall_cnt     = '0;
  assign squash_cnt    = '0;
  assign max_stall_run = '0;
`endif

endmodule
